vga_sync_gen: RTL and testbench

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 104 ++++++++++
 tb/tb_vga_sync_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA sync generator: pixel/line counters advanced on a dclk rising-edge
// tick, with hsync/vsync/video_on decodes and a registered frame_start pulse.
// Optional macro VGA_SYNC_PIPELINE_EN registers hsync/vsync/video_on on tick
// (one tick behind hc/vc); otherwise they are zero-latency decodes.
module vga_sync_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dclk,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic dclk_q;
  logic tick;
  logic run;
  logic hs_dec, vs_dec, vid_dec;

  // Delay dclk by one clk so its rising edge can be detected as data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dclk_q <= 1'b0;
    else        dclk_q <= dclk;
  end

  assign tick = dclk & ~dclk_q;

  // Pixel/line counters; the combined (H_LAST,V_LAST) wrap is one event that
  // also raises frame_start for the following clk cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc          <= '0;
      vc          <= '0;
      run         <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (tick) begin
        run <= 1'b1;
        if (hc == H_LAST) begin
          hc <= '0;
          if (vc == V_LAST) begin
            vc          <= '0;
            frame_start <= 1'b1;
          end else begin
            vc <= vc + 10'd1;
          end
        end else begin
          hc <= hc + 10'd1;
        end
      end
    end
  end

  // Sync/visible decode of the current counter values.
  always_comb begin
    hs_dec  = !((hc >= HS_BEG) && (hc < HS_END));
    vs_dec  = !((vc >= VS_BEG) && (vc < VS_END));
    vid_dec = (hc < H_VIS) && (vc < V_VIS) && run;
  end

`ifdef VGA_SYNC_PIPELINE_EN
  // Registered outputs: capture the decode on each tick, so they trail hc/vc by one tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else if (tick) begin
      hsync    <= hs_dec;
      vsync    <= vs_dec;
      video_on <= vid_dec;
    end
  end
`else
  assign hsync    = hs_dec;
  assign vsync    = vs_dec;
  assign video_on = vid_dec;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. Vertical timing is shrunk to 8 lines
// (4 visible, front 1, sync 2, back 1) so a whole frame fits a short run;
// horizontal timing keeps the 640/16/96/48 defaults.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPELINE_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dclk = 1'b0;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] hc, vc;

  int n_cmp  = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  int fs_hc  = -1;
  int fs_vc  = -1;

  vga_sync_gen #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(4),   .V_FRONT(1),  .V_SYNC(2),  .V_BACK(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dclk(dclk),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .hc(hc), .vc(vc), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Count frame_start pulses mid-cycle and note where the counters sit.
  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt++;
      fs_hc = int'(hc);
      fs_vc = int'(vc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // dclk toggling every 2 clk: one tick per 4 clk. Entered and left at posedge+1.
  task automatic tick_slow();
    dclk = 1'b1;
    repeat (2) @(posedge clk);
    #1 dclk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // dclk toggling every clk: one tick per 2 clk.
  task automatic tick_fast();
    dclk = 1'b1;
    @(posedge clk);
    #1 dclk = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dclk  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lows, first_low, vis_cnt, vc_at_wrap, vs_lows, max_h, max_v, fs_before;
    logic [9:0] h0, v0;

    // Reset state, no clock edge yet.
    #1;
    chk("rst_hc", hc, 0);
    chk("rst_vc", vc, 0);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_video_on", video_on, 0);
    chk("rst_frame_start", frame_start, 0);

    do_reset();
    chk("idle_video_on", video_on, 0);

    // First tick: hc advances to 1, run is set.
    tick_slow();
    chk("tick1_hc", hc, 1);
    chk("tick1_vc", vc, 0);
    chk("tick1_video_on", video_on, (LAG == 0) ? 1 : 0);
    tick_slow();
    chk("tick2_hc", hc, 2);
    chk("tick2_video_on", video_on, 1);

    // 800 ticks across a line boundary (hc 3..799,0,1,2).
    lows = 0; first_low = -1; vis_cnt = 0; vc_at_wrap = -1;
    for (int t = 0; t < 800; t++) begin
      tick_slow();
      if (hsync === 1'b0) begin
        if (first_low < 0) first_low = int'(hc);
        lows++;
      end
      if (video_on === 1'b1) vis_cnt++;
      if (hc == 10'd0) vc_at_wrap = int'(vc);
    end
    chk("hsync_low_ticks", lows, 96);
    chk("hsync_first_low_hc", first_low, 656 + LAG);
    chk("video_on_ticks", vis_cnt, 640);
    chk("vc_after_hwrap", vc_at_wrap, 1);
    chk("line_end_hc", hc, 2);

    // Full frame from (0,0): 800*8 = 6400 ticks.
    do_reset();
    fs_before = fs_cnt;
    vs_lows = 0; max_h = 0; max_v = 0;
    for (int t = 0; t < 6400; t++) begin
      tick_fast();
      if (vsync === 1'b0) vs_lows++;
      if (int'(hc) > max_h) max_h = int'(hc);
      if (int'(vc) > max_v) max_v = int'(vc);
    end
    chk("vsync_low_ticks", vs_lows, 1600);
    chk("frame_start_pulses", fs_cnt - fs_before, 1);
    chk("frame_start_hc", fs_hc, 0);
    chk("frame_start_vc", fs_vc, 0);
    chk("max_hc", max_h, 799);
    chk("max_vc", max_v, 7);
    chk("frame_end_hc", hc, 0);
    chk("frame_end_vc", vc, 0);

    // Reset in the middle of a frame at (300,3).
    do_reset();
    for (int t = 0; t < 2700; t++) tick_fast();
    chk("mid_hc", hc, 300);
    chk("mid_vc", vc, 3);
    chk("mid_video_on", video_on, 1);
    fs_before = fs_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_hc", hc, 0);
    chk("async_rst_vc", vc, 0);
    chk("async_rst_hsync", hsync, 1);
    chk("async_rst_vsync", vsync, 1);
    chk("async_rst_video_on", video_on, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick_slow();
    chk("restart_hc", hc, 1);
    chk("restart_vc", vc, 0);
    chk("no_abandoned_fs", fs_cnt - fs_before, 0);

    // dclk held high: only its rising edge ticks, then everything holds.
    dclk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    h0 = hc; v0 = vc;
    chk("hold_entry_hc", h0, 2);
    repeat (100) @(posedge clk);
    #1;
    chk("hold_hc", hc, h0);
    chk("hold_vc", vc, v0);
    dclk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("hold_low_hc", hc, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
